matrix_scale_acc: RTL

Parametrised ROWS x COLS matrix of W-bit counters. Each cycle an optional increment is applied to one addressed element. On request, a sequential scan engine produces a scaled copy of the matrix with result(r,c) = (r+1)*(c+1)*arr(r,c), one element per cycle. The scaled copy is published on a flat output bus. Successor to the fixed 2x3x8 combinational scale-and-accumulate block: generalised dimensions, handshake, snapshot semantics and error reporting.

---
 rtl/matrix_scale_pkg.sv | 26 ++
 rtl/scale_elem.sv | 27 ++
 rtl/matrix_scale_acc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/matrix_scale_pkg.sv
// Shared types and helpers for the matrix scale-and-accumulate block.
package matrix_scale_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // ceil(log2(n)); 0 for n <= 1
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // row-major flat element index
   function automatic int idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

   // full-width product: element times (r+1)*(c+1) never overflows this
   function automatic int prod_w(input int w, input int rows, input int cols);
      return w + clog2(rows) + clog2(cols) + 2;
   endfunction

   localparam int PROD_W_DEF = prod_w(8, 2, 3);

endpackage

// File: rtl/scale_elem.sv
// Combinational (r+1)*(c+1)*elem. SATURATE_EN clamps to the W-bit max,
// otherwise the full-width product is truncated to W bits.
module scale_elem #(
   parameter int W  = 8,
   parameter int RW = 1,
   parameter int CW = 2,
   parameter int PW = 13
) (
   input  logic [W-1:0]  elem,
   input  logic [RW-1:0] row,
   input  logic [CW-1:0] col,
   output logic [W-1:0]  res
);

   logic [PW-1:0] factor;

   assign factor = (PW'(row) + PW'(1)) * (PW'(col) + PW'(1));

`ifdef SATURATE_EN
   logic [PW-1:0] prod;
   assign prod = factor * PW'(elem);
   assign res  = (prod > PW'({W{1'b1}})) ? {W{1'b1}} : prod[W-1:0];
`else
   assign res  = W'(factor * PW'(elem));
`endif

endmodule

// File: rtl/matrix_scale_acc.sv
// ROWS x COLS counter matrix with a sequential scaled-copy scan engine.
// One scale_elem is time-shared over a snapshot taken at start, so
// increments during a scan never leak into the result.
// Optional macro SATURATE_EN: saturating increment and clamped products.
module matrix_scale_acc
   import matrix_scale_pkg::*;
#(
   parameter int ROWS  = 2,
   parameter int COLS  = 3,
   parameter int W     = 8,
   parameter int IDX_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc_valid,
   input  logic [IDX_W-1:0]       inc_row,
   input  logic [IDX_W-1:0]       inc_col,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [ROWS*COLS*W-1:0] flat
);

   localparam int N  = ROWS * COLS;
   localparam int PW = (clog2(N) > 0) ? clog2(N) : 1;
   localparam int RW = (clog2(ROWS) > 0) ? clog2(ROWS) : 1;
   localparam int CW = (clog2(COLS) > 0) ? clog2(COLS) : 1;

   typedef logic [N-1:0][W-1:0] mat_t;

   mat_t          arr, snap, res;
   state_t        state;
   logic [PW-1:0] pos;
   logic [RW-1:0] sr;
   logic [CW-1:0] sc;
   logic [W-1:0]  scaled;
   logic          inc_ok;

   // extra top bit keeps the compare unsigned for any IDX_W
   assign inc_ok = ({1'b0, inc_row} < (IDX_W+1)'(ROWS)) &&
                   ({1'b0, inc_col} < (IDX_W+1)'(COLS));

   // matrix increments (any FSM state) and sticky range error
   always_ff @(posedge clk) begin
      if (rst) begin
         arr <= '0;
         err <= 1'b0;
      end else if (inc_valid) begin
         if (!inc_ok) err <= 1'b1;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (inc_ok && {1'b0, inc_row} == (IDX_W+1)'(r) &&
                   {1'b0, inc_col} == (IDX_W+1)'(c)) begin
`ifdef SATURATE_EN
                  if (arr[idx(r, c, COLS)] != {W{1'b1}})
                     arr[idx(r, c, COLS)] <= arr[idx(r, c, COLS)] + 1'b1;
`else
                  arr[idx(r, c, COLS)] <= arr[idx(r, c, COLS)] + 1'b1;
`endif
               end
            end
         end
      end
   end

   scale_elem #(.W(W), .RW(RW), .CW(CW), .PW(prod_w(W, ROWS, COLS))) u_scale (
      .elem (snap[pos]),
      .row  (sr),
      .col  (sc),
      .res  (scaled)
   );

   // scan FSM: snapshot, walk row-major writing results, publish atomically
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         snap  <= '0;
         res   <= '0;
         flat  <= '0;
         pos   <= '0;
         sr    <= '0;
         sc    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snap  <= arr;
                  pos   <= '0;
                  sr    <= '0;
                  sc    <= '0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               res[pos] <= scaled;
               if (pos == PW'(N-1)) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  pos <= pos + 1'b1;
                  if (sc == CW'(COLS-1)) begin
                     sc <= '0;
                     sr <= sr + 1'b1;
                  end else begin
                     sc <= sc + 1'b1;
                  end
               end
            end
            DONE: begin
               flat  <= res;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
